card_jitsu: RTL and testbench
=============================

// Module: card_jitsu
// PURPOSE
//  Single-player Card-Jitsu game (fire/water/snow rock-paper-scissors with card values) against a pseudo-random CPU.
//  Player picks a card on sw and plays it with btn_0. The block reveals the round result on an RGB LED,
//  tracks element wins per side and declares a game winner. Top-level board block; drives LEDs directly.
// PARAMETERS
//  LFSR_SEED  8'hA5  reset value of the CPU card LFSR; must be nonzero
// PORTS
//  clk     in   1  system clock; all logic on its rising edge
//  rst     in   1  synchronous, active-high reset
//  btn_0   in   1  play selected card (level input, edge-detected internally)
//  btn_1   in   1  acknowledge round result / continue
//  btn_2   in   1  new game (clears scores)
//  sw      in   4  player card: sw[1:0] element (00 fire, 01 water, 10 snow, 11 invalid), sw[3:2] value 0..3
//  leds    out  4  status/score display (per state, below)
//  led6_r  out  1  RGB red: CPU won round/game
//  led6_g  out  1  RGB green: player won round/game
//  led6_b  out  1  RGB blue: tie round
// BEHAVIOUR
//  Reset: state=SELECT, all six score counters=0, lfsr=LFSR_SEED, leds=0000, led6_r/g/b=0; button sync and delay regs=0.
//  - All outputs are registered.
//  Buttons: each btn_x is registered into btn_x_s, then into btn_x_d; press pulse = btn_x_s & ~btn_x_d.
//  - The action registers on the 2nd rising edge at which the button is sampled high.
//  - Holding a button produces exactly one pulse.
//  - Priority when pulses coincide: btn_2 > btn_0 > btn_1. Pulses irrelevant to the current state are ignored.
//  LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1.
//  - Shift: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//  - Steps every cycle when not in reset, in all states.
//  CPU card: latched from lfsr in the same edge the btn_0 pulse is accepted.
//  - cpu_elem = (lfsr[1:0]==2'b11) ? 2'b00 : lfsr[1:0]; cpu_val = lfsr[3:2].
//  Round rule:
//  - Different elements: fire beats snow, snow beats water, water beats fire.
//  - Same element: higher value wins; equal values = tie.
//  Scoring: the winner's counter for the winning card's element is incremented, saturating at 3. A tie scores nothing.
//  Game win for a side: any counter == 3, OR all three of its counters nonzero. Evaluated on scores after the round.
//  States:
//  - SELECT: leds = {1'b0, p_snow!=0, p_water!=0, p_fire!=0}, RGB off.
//    - btn_0 with sw[1:0]!=11: latch player card, latch CPU card, score; next = REVEAL.
//    - btn_0 with sw[1:0]==11: ignored, stay in SELECT.
//  - REVEAL: leds = {cpu_val, cpu_elem}. RGB one-hot: g = player won, r = CPU won, b = tie.
//    - btn_1: next = GAMEOVER if either side has a game win, else SELECT.
//  - GAMEOVER: player won → leds=1111, g=1; CPU won → leds=0000, r=1. Only btn_2 leaves.
//  - btn_2 in any state: clear all counters, RGB off, next = SELECT. LFSR is not reseeded.
//  - sw changes outside the btn_0 accept edge have no effect.
//  - rst asserted mid-game returns everything to reset values on the next edge, regardless of buttons.
//  - Unused state encodings recover to SELECT.
// TESTING
//  - Reset: rst=1 for 1 cycle, then release → leds=0000, RGB=000, state SELECT; lfsr == 8'hA5 on the first cycle after release.
//  - Invalid card: sw=4'b0011, pulse btn_0 → stays in SELECT; leds=0000, RGB=000.
//  - Round result: reference-model the LFSR to predict the CPU card.
//    - Play sw=4'b1100 (fire, value 3); on btn_0 pulse+1 cycle, leds={cpu_val,cpu_elem}.
//    - If CPU card is fire/3 → b=1; snow → g=1; water → r=1 (with matching score changes).
//    - Play ordering is fixed (cycle-exact) so the outcome is fully determined.
//  - Button edges: hold btn_0 high 20 cycles → exactly one round scored. btn_0 and btn_2 together → only the clear happens.
//  - Game win: repeat rounds, modeling the LFSR, until the player holds fire/water/snow ≥1 each.
//    - btn_1 → GAMEOVER, leds=1111, g=1.
//    - Then btn_2 → SELECT, leds=0000, RGB=000, counters 0.
//  - Reset mid-game: assert rst while in REVEAL → all outputs 0 after that edge, scores cleared.

Source files
------------

// File: rtl/card_jitsu.sv
// Card-Jitsu board game: player card on sw against an LFSR-driven CPU card.
// Shows round results on the RGB LED and tracks per-element wins for both sides.
module card_jitsu #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_0,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic [3:0] sw,
  output logic [3:0] leds,
  output logic       led6_r,
  output logic       led6_g,
  output logic       led6_b
);

  localparam int unsigned ELEM_W  = 2;
  localparam int unsigned SCORE_W = 2;
  localparam int unsigned N_ELEM  = 3;

  localparam logic [ELEM_W-1:0]  FIRE      = 2'd0;
  localparam logic [ELEM_W-1:0]  WATER     = 2'd1;
  localparam logic [ELEM_W-1:0]  SNOW      = 2'd2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 2'd3;

  typedef enum logic [1:0] {
    SELECT   = 2'd0,
    REVEAL   = 2'd1,
    GAMEOVER = 2'd2
  } state_t;

  state_t                            state;
  logic [7:0]                        lfsr;
  logic [2:0]                        btn_s;
  logic [2:0]                        btn_d;
  logic [N_ELEM-1:0][SCORE_W-1:0]    p_sc;
  logic [N_ELEM-1:0][SCORE_W-1:0]    c_sc;

  logic [2:0]        pulse_c;
  logic [7:0]        lfsr_next_c;
  logic [ELEM_W-1:0] cpu_elem_c;
  logic [1:0]        cpu_val_c;
  logic [ELEM_W-1:0] p_elem_c;
  logic [1:0]        p_val_c;
  logic              card_ok_c;
  logic              p_wins_c;
  logic              c_wins_c;
  logic              p_game_c;
  logic              c_game_c;
  logic [3:0]        select_leds_c;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] x);
    return (x == SCORE_MAX) ? x : x + SCORE_W'(1);
  endfunction

  function automatic logic game_won(input logic [N_ELEM-1:0][SCORE_W-1:0] sc);
    return (sc[0] == SCORE_MAX) || (sc[1] == SCORE_MAX) || (sc[2] == SCORE_MAX) ||
           ((sc[0] != '0) && (sc[1] != '0) && (sc[2] != '0));
  endfunction

  assign pulse_c       = btn_s & ~btn_d;
  assign lfsr_next_c   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign cpu_elem_c    = (lfsr[1:0] == 2'b11) ? FIRE : lfsr[1:0];
  assign cpu_val_c     = lfsr[3:2];
  assign p_elem_c      = sw[1:0];
  assign p_val_c       = sw[3:2];
  assign card_ok_c     = (sw[1:0] != 2'b11);
  assign p_game_c      = game_won(p_sc);
  assign c_game_c      = game_won(c_sc);
  assign select_leds_c = {1'b0, p_sc[2] != '0, p_sc[1] != '0, p_sc[0] != '0};

  // Round outcome for the card on sw against the CPU card currently in the LFSR.
  always_comb begin
    p_wins_c = 1'b0;
    c_wins_c = 1'b0;
    if (p_elem_c == cpu_elem_c) begin
      p_wins_c = (p_val_c > cpu_val_c);
      c_wins_c = (p_val_c < cpu_val_c);
    end else begin
      p_wins_c = ((p_elem_c == FIRE)  && (cpu_elem_c == SNOW))  ||
                 ((p_elem_c == SNOW)  && (cpu_elem_c == WATER)) ||
                 ((p_elem_c == WATER) && (cpu_elem_c == FIRE));
      c_wins_c = ~p_wins_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SELECT;
      lfsr   <= LFSR_SEED;
      btn_s  <= '0;
      btn_d  <= '0;
      p_sc   <= '0;
      c_sc   <= '0;
      leds   <= '0;
      led6_r <= 1'b0;
      led6_g <= 1'b0;
      led6_b <= 1'b0;
    end else begin
      lfsr  <= lfsr_next_c;
      btn_s <= {btn_2, btn_1, btn_0};
      btn_d <= btn_s;
      // New game outranks every other press.
      if (pulse_c[2]) begin
        state  <= SELECT;
        p_sc   <= '0;
        c_sc   <= '0;
        leds   <= '0;
        led6_r <= 1'b0;
        led6_g <= 1'b0;
        led6_b <= 1'b0;
      end else begin
        case (state)
          SELECT: begin
            if (pulse_c[0] && card_ok_c) begin
              state  <= REVEAL;
              leds   <= {cpu_val_c, cpu_elem_c};
              led6_g <= p_wins_c;
              led6_r <= c_wins_c;
              led6_b <= ~p_wins_c & ~c_wins_c;
              if (p_wins_c) p_sc[p_elem_c] <= sat_inc(p_sc[p_elem_c]);
              if (c_wins_c) c_sc[cpu_elem_c] <= sat_inc(c_sc[cpu_elem_c]);
            end else begin
              leds   <= select_leds_c;
              led6_r <= 1'b0;
              led6_g <= 1'b0;
              led6_b <= 1'b0;
            end
          end
          REVEAL: begin
            if (pulse_c[1]) begin
              led6_b <= 1'b0;
              if (p_game_c) begin
                state  <= GAMEOVER;
                leds   <= 4'b1111;
                led6_g <= 1'b1;
                led6_r <= 1'b0;
              end else if (c_game_c) begin
                state  <= GAMEOVER;
                leds   <= 4'b0000;
                led6_g <= 1'b0;
                led6_r <= 1'b1;
              end else begin
                state  <= SELECT;
                leds   <= select_leds_c;
                led6_g <= 1'b0;
                led6_r <= 1'b0;
              end
            end
          end
          GAMEOVER: begin
            state <= GAMEOVER;
          end
          default: begin
            state  <= SELECT;
            leds   <= select_leds_c;
            led6_r <= 1'b0;
            led6_g <= 1'b0;
            led6_b <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_jitsu.sv
// Self-checking bench for card_jitsu: predicts CPU cards by counting LFSR steps
// since reset and scores rounds with a modular element-distance model.
module tb_card_jitsu;

  logic       TbClock = 1'b0;
  logic       rst;
  logic       btn_0;
  logic       btn_1;
  logic       btn_2;
  logic [3:0] sw;
  logic [3:0] leds;
  logic       led6_r;
  logic       led6_g;
  logic       led6_b;

  int checks = 0;
  int errors = 0;
  int steps  = 0;
  int ps[3];
  int cs[3];
  bit game_over;

  always #5 TbClock = ~TbClock;

  card_jitsu #(.LFSR_SEED(8'hA5)) dut (
    .clk    (TbClock),
    .rst    (rst),
    .btn_0  (btn_0),
    .btn_1  (btn_1),
    .btn_2  (btn_2),
    .sw     (sw),
    .leds   (leds),
    .led6_r (led6_r),
    .led6_g (led6_g),
    .led6_b (led6_b)
  );

  // Number of LFSR steps taken since the last reset edge.
  always @(posedge TbClock) begin
    if (rst) steps = 0;
    else     steps = steps + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic bit wins_game(input int s0, input int s1, input int s2);
    return (s0 == 3) || (s1 == 3) || (s2 == 3) || ((s0 > 0) && (s1 > 0) && (s2 > 0));
  endfunction

  function automatic logic [3:0] select_leds();
    return {1'b0, ps[2] > 0, ps[1] > 0, ps[0] > 0};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      ps[i] = 0;
      cs[i] = 0;
    end
    game_over = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge TbClock);
    #1;
  endtask

  // Plays one card; optionally acknowledges and/or keeps btn_0 held afterwards.
  task automatic play_round(input logic [3:0] card, input bit ack, input bit keep_btn0);
    logic [7:0] lf;
    logic [2:0] exp_rgb;
    logic [3:0] exp_leds;
    int ce, cv, pe, pv;
    bit pw, cw;
    sw    = card;
    btn_0 = 1'b1;
    tick(2);
    lf = lfsr_at(steps - 1);
    ce = (lf[1:0] == 2'b11) ? 0 : int'(lf[1:0]);
    cv = int'(lf[3:2]);
    pe = int'(card[1:0]);
    pv = int'(card[3:2]);
    if (pe == ce) begin
      pw = (pv > cv);
      cw = (pv < cv);
    end else begin
      pw = (((pe - ce + 3) % 3) == 1);
      cw = (((pe - ce + 3) % 3) == 2);
    end
    if (pw) ps[pe] = (ps[pe] < 3) ? ps[pe] + 1 : 3;
    if (cw) cs[ce] = (cs[ce] < 3) ? cs[ce] + 1 : 3;
    exp_rgb  = {cw, pw, !pw && !cw};
    exp_leds = 4'(cv * 4 + ce);
    checks++;
    if (leds !== exp_leds) begin
      errors++;
      $display("FAIL reveal_leds card=%b got %b want %b", card, leds, exp_leds);
    end
    checks++;
    if ({led6_r, led6_g, led6_b} !== exp_rgb) begin
      errors++;
      $display("FAIL reveal_rgb card=%b got %b want %b", card, {led6_r, led6_g, led6_b}, exp_rgb);
    end
    if (!keep_btn0) btn_0 = 1'b0;
    if (ack) begin
      btn_1 = 1'b1;
      tick(2);
      btn_1 = 1'b0;
      if (wins_game(ps[0], ps[1], ps[2])) begin
        exp_leds = 4'b1111; exp_rgb = 3'b010; game_over = 1'b1;
      end else if (wins_game(cs[0], cs[1], cs[2])) begin
        exp_leds = 4'b0000; exp_rgb = 3'b100; game_over = 1'b1;
      end else begin
        exp_leds = select_leds(); exp_rgb = 3'b000;
      end
      checks++;
      if (leds !== exp_leds) begin
        errors++;
        $display("FAIL ack_leds got %b want %b", leds, exp_leds);
      end
      checks++;
      if ({led6_r, led6_g, led6_b} !== exp_rgb) begin
        errors++;
        $display("FAIL ack_rgb got %b want %b", {led6_r, led6_g, led6_b}, exp_rgb);
      end
    end
    tick(1);
  endtask

  task automatic press_clear();
    btn_2 = 1'b1;
    tick(2);
    btn_2 = 1'b0;
    clear_model();
    checks++;
    if (leds !== 4'b0000) begin
      errors++;
      $display("FAIL clear_leds got %b want 0000", leds);
    end
    checks++;
    if ({led6_r, led6_g, led6_b} !== 3'b000) begin
      errors++;
      $display("FAIL clear_rgb got %b want 000", {led6_r, led6_g, led6_b});
    end
    tick(2);
  endtask

  // Waits for a CPU card the player can beat with a still-empty element, then plays it.
  task automatic play_win();
    logic [7:0] lf;
    int ce, cv;
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      lf = lfsr_at(steps + 1);
      ce = (lf[1:0] == 2'b11) ? 0 : int'(lf[1:0]);
      cv = int'(lf[3:2]);
      for (int x = 0; x < 3 && !done; x++) begin
        if (ps[x] == 0) begin
          if (((x - ce + 3) % 3) == 1) begin
            play_round({2'($urandom_range(0, 3)), 2'(x)}, 1'b1, 1'b0);
            done = 1'b1;
          end else if ((x == ce) && (cv < 3)) begin
            play_round({2'd3, 2'(x)}, 1'b1, 1'b0);
            done = 1'b1;
          end
        end
      end
      if (!done) tick(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL play_win no winnable card within budget got 0 want 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_0 = 1'b0; btn_1 = 1'b0; btn_2 = 1'b0; sw = 4'b0000;
    tick(1);
    rst = 1'b0;
    clear_model();
    checks++;
    if (leds !== 4'b0000) begin
      errors++;
      $display("FAIL reset_leds got %b want 0000", leds);
    end
    checks++;
    if ({led6_r, led6_g, led6_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rgb got %b want 000", {led6_r, led6_g, led6_b});
    end
  endtask

  task automatic test_invalid();
    sw = 4'b0011;
    btn_0 = 1'b1;
    tick(2);
    btn_0 = 1'b0;
    tick(2);
    checks++;
    if (leds !== 4'b0000) begin
      errors++;
      $display("FAIL invalid_leds got %b want 0000", leds);
    end
    checks++;
    if ({led6_r, led6_g, led6_b} !== 3'b000) begin
      errors++;
      $display("FAIL invalid_rgb got %b want 000", {led6_r, led6_g, led6_b});
    end
  endtask

  task automatic test_fire3();
    play_round(4'b1100, 1'b1, 1'b0);
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 30; r++) begin
      tick($urandom_range(1, 4));
      play_round({2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))}, 1'b1, 1'b0);
      if (game_over) press_clear();
    end
  endtask

  task automatic test_priority();
    press_clear();
    play_win();
    sw    = 4'b0100;
    btn_0 = 1'b1;
    btn_2 = 1'b1;
    tick(2);
    btn_0 = 1'b0;
    btn_2 = 1'b0;
    clear_model();
    checks++;
    if ({leds, led6_r, led6_g, led6_b} !== 7'b0) begin
      errors++;
      $display("FAIL prio_clear got %b want 0000000", {leds, led6_r, led6_g, led6_b});
    end
    tick(3);
    checks++;
    if ({leds, led6_r, led6_g, led6_b} !== 7'b0) begin
      errors++;
      $display("FAIL prio_no_round got %b want 0000000", {leds, led6_r, led6_g, led6_b});
    end
  endtask

  task automatic test_hold();
    press_clear();
    play_round({2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))}, 1'b1, 1'b1);
    tick(16);
    checks++;
    if ({led6_r, led6_g, led6_b} !== 3'b000) begin
      errors++;
      $display("FAIL hold_rgb got %b want 000", {led6_r, led6_g, led6_b});
    end
    checks++;
    if (leds !== select_leds()) begin
      errors++;
      $display("FAIL hold_leds got %b want %b", leds, select_leds());
    end
    btn_0 = 1'b0;
    tick(2);
  endtask

  task automatic test_game_win();
    press_clear();
    for (int r = 0; r < 5 && !game_over; r++) play_win();
    checks++;
    if ({leds, led6_r, led6_g, led6_b} !== 7'b1111_010) begin
      errors++;
      $display("FAIL gameover got %b want 1111010", {leds, led6_r, led6_g, led6_b});
    end
    press_clear();
  endtask

  task automatic test_reset_mid();
    play_round({2'($urandom_range(0, 3)), 2'($urandom_range(0, 2))}, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_model();
    checks++;
    if ({leds, led6_r, led6_g, led6_b} !== 7'b0) begin
      errors++;
      $display("FAIL midreset got %b want 0000000", {leds, led6_r, led6_g, led6_b});
    end
    play_round(4'b1100, 1'b1, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    btn_2 = 1'b0;
    sw    = 4'b0000;
    clear_model();
    test_reset();
    test_invalid();
    test_fire3();
    test_random_rounds();
    test_priority();
    test_hold();
    test_game_win();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
